cga_io_initiator: RTL and testbench
===================================

CGA_IO_INITIATOR -- requirements
Module: cga_io_initiator

Interface
REQ-001 Parameters SHALL be, one per line:
- SETUP_CYCLES, 1, cycles address/data are valid before the strobe asserts (min 1).
- STROBE_CYCLES, 3, minimum strobe-low cycles (min 2; the responder synchronizes strobes by one cycle).
- HOLD_CYCLES, 1, cycles address/data are held after the strobe deasserts (min 1).
- RDY_TIMEOUT, 64, maximum extra strobe cycles while bus_rdy is low (min 1).
REQ-002 The block SHALL use one clock; reset is asynchronous and active-high. Ports are named clk and reset.
REQ-003 Ports SHALL be, one per line:
- clk  in  1  system clock, shared with the CGA responder.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  host requests an I/O cycle.
- req_ready  out  1  block accepts the request (IDLE only).
- req_write  in  1  1 = IOW cycle, 0 = IOR cycle.
- req_addr  in  15  I/O address.
- req_wdata  in  8  write data.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  8  read data; FF for writes and floating reads.
- rsp_timeout  out  1  qualifies rsp_valid; the bus_rdy timeout expired.
- bus_a  out  15  ISA address.
- bus_ior_l  out  1  I/O read strobe, active low.
- bus_iow_l  out  1  I/O write strobe, active low.
- bus_aen  out  1  address enable; high blocks responder decode.
- bus_d_out  out  8  write data to the responder.
- bus_d_oe  out  1  bus_d_out is driven.
- bus_in  in  8  responder read data.
- bus_dir  in  1  responder is driving bus_in.
- bus_rdy  in  1  IOCHRDY; low inserts wait states.

Function
REQ-004 The FSM SHALL have the states IDLE, SETUP, STROBE, WAIT, HOLD and RESP; req_ready = 1 only in IDLE.
REQ-005 In IDLE, on req_valid & req_ready, the block SHALL latch req_write, req_addr and req_wdata and enter SETUP at the next edge.
REQ-006 In IDLE, outputs SHALL be: bus_a = 0, both strobes = 1, bus_aen = 1, bus_d_oe = 0, bus_d_out = 0.
REQ-007 From SETUP through HOLD, outputs SHALL be: bus_a = latched address, bus_aen = 0, bus_d_oe = latched write, bus_d_out = latched data.
REQ-008 SETUP SHALL last SETUP_CYCLES with both strobes high, then go to STROBE.
REQ-009 In STROBE and WAIT, bus_iow_l (write) or bus_ior_l (read) SHALL be low; the other strobe stays high.
REQ-010 STROBE SHALL last STROBE_CYCLES. On its final cycle, the block goes to HOLD if bus_rdy = 1, else to WAIT.
REQ-011 WAIT SHALL go to HOLD in the cycle after bus_rdy is sampled high. After RDY_TIMEOUT WAIT cycles, it goes to HOLD with a sticky timeout flag set.
REQ-012 Read data SHALL be captured on the edge leaving STROBE or WAIT: bus_in if bus_dir = 1, else 8'hFF. On timeout, or for writes, the captured value is 8'hFF.
REQ-013 HOLD SHALL last HOLD_CYCLES with both strobes high, then go to RESP.
REQ-014 RESP SHALL last one cycle with rsp_valid = 1, rsp_rdata = captured data, rsp_timeout = flag; it then returns to IDLE.
REQ-015 rsp_rdata SHALL hold its value until the next RESP.
REQ-016 With default parameters and bus_rdy = 1, if acceptance occurs at edge T0, the strobe SHALL be low in cycles T2–T4 and rsp_valid SHALL be high in cycle T6. The next acceptance is possible no earlier than T7.
REQ-017 Requests presented outside IDLE SHALL be ignored without latching; req_valid held high is accepted once per transaction.
REQ-018 Both strobes SHALL never be low simultaneously, and no strobe SHALL be low while bus_aen = 1.

Reset
REQ-019 Assertion of reset SHALL force the IDLE state and IDLE output values asynchronously. It also clears rsp_valid, rsp_timeout, the timeout flag and all counters, and sets rsp_rdata to 8'hFF.
REQ-020 Reset mid-transaction SHALL abort the transaction without producing rsp_valid.

Structure
REQ-021 The state enumeration and the default timing constants SHALL reside in a shared package, cga_io_pkg.
REQ-022 The block SHALL instantiate one sub-module, isa_cycle_timer: a loadable down-counter with a done flag, sized for max(STROBE_CYCLES, RDY_TIMEOUT). The timer serves the SETUP, STROBE, WAIT and HOLD phases.

Verification
REQ-023 Write 3D8 with data 29, bus_rdy = 1 -> bus_iow_l low for exactly 3 cycles, bus_d_out = 29, bus_a = 3D8, rsp_valid 6 cycles after acceptance, rsp_rdata = FF.
REQ-024 Read 3DA with bus_dir = 1 and bus_in = F1 -> bus_ior_l low for 3 cycles, rsp_rdata = F1, rsp_timeout = 0.
REQ-025 Read 3DF with bus_dir = 0 -> rsp_rdata = FF; bus_iow_l stays high throughout.
REQ-026 bus_rdy low for 5 cycles starting at the first strobe cycle -> strobe low for 8 cycles total, rsp_timeout = 0.
REQ-027 bus_rdy stuck low -> strobe releases after 3 + 64 cycles, rsp_timeout = 1, rsp_rdata = FF.
REQ-028 reset asserted in the second STROBE cycle -> strobes high and bus_aen = 1 in the same cycle, no rsp_valid, req_ready = 1 after release.

Source files
------------

// File: rtl/cga_io_pkg.sv
// Shared FSM encoding and default bus timing for the CGA I/O initiator.
package cga_io_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StStrobe,
        StWait,
        StHold,
        StResp
    } state_e;

    localparam int unsigned SETUP_CYCLES_DEF  = 1;
    localparam int unsigned STROBE_CYCLES_DEF = 3;
    localparam int unsigned HOLD_CYCLES_DEF   = 1;
    localparam int unsigned RDY_TIMEOUT_DEF   = 64;

    // Value returned for writes, floating reads and timed-out cycles.
    localparam logic [7:0] FLOAT_DATA = 8'hFF;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/cga_io_initiator_if.sv
// Host request/response and ISA I/O bus signals of the CGA I/O initiator.
interface cga_io_initiator_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [14:0] req_addr;
    logic [7:0]  req_wdata;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_timeout;
    logic [14:0] bus_a;
    logic        bus_ior_l;
    logic        bus_iow_l;
    logic        bus_aen;
    logic [7:0]  bus_d_out;
    logic        bus_d_oe;
    logic [7:0]  bus_in;
    logic        bus_dir;
    logic        bus_rdy;

    // Initiator view.
    modport master (
        input  req_valid, req_write, req_addr, req_wdata, bus_in, bus_dir, bus_rdy,
        output req_ready, rsp_valid, rsp_rdata, rsp_timeout,
        output bus_a, bus_ior_l, bus_iow_l, bus_aen, bus_d_out, bus_d_oe
    );

    // Host plus responder view.
    modport slave (
        output req_valid, req_write, req_addr, req_wdata, bus_in, bus_dir, bus_rdy,
        input  req_ready, rsp_valid, rsp_rdata, rsp_timeout,
        input  bus_a, bus_ior_l, bus_iow_l, bus_aen, bus_d_out, bus_d_oe
    );

endinterface

// File: rtl/isa_cycle_timer.sv
// Loadable down-counter that times each ISA cycle phase; done marks a phase's last cycle.
module isa_cycle_timer #(
    parameter int unsigned Width = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [Width-1:0] load_val,
    output logic             done
);

    logic [Width-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - Width'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done = (count_q == '0);

endmodule

// File: rtl/cga_io_initiator.sv
// ISA I/O cycle initiator towards the CGA responder: sequences setup, strobe, wait-state,
// hold and response phases for one host request at a time.
module cga_io_initiator
    import cga_io_pkg::*;
#(
    parameter int unsigned SETUP_CYCLES  = SETUP_CYCLES_DEF,
    parameter int unsigned STROBE_CYCLES = STROBE_CYCLES_DEF,
    parameter int unsigned HOLD_CYCLES   = HOLD_CYCLES_DEF,
    parameter int unsigned RDY_TIMEOUT   = RDY_TIMEOUT_DEF
) (
    input logic               clk,
    input logic               reset,
    cga_io_initiator_if.master bus
);

    localparam int unsigned TimerMax =
        max_u(max_u(SETUP_CYCLES, HOLD_CYCLES), max_u(STROBE_CYCLES, RDY_TIMEOUT));
    localparam int unsigned TimerW = $clog2(TimerMax + 1);

    state_e              state_q, state_d;
    logic                tmr_load;
    logic [TimerW-1:0]   tmr_val;
    logic                tmr_done;

    logic                write_q, write_d;
    logic [14:0]         addr_q, addr_d;
    logic [7:0]          wdata_q, wdata_d;
    logic [7:0]          cap_q, cap_d;
    logic [7:0]          rdata_q, rdata_d;
    logic                tmo_q, tmo_d;
    logic [1:0]          rdy_sync_q;
    logic                rdy_ok;
    logic                rdy_expired;

    // IOCHRDY passes through two flops before it can end the strobe.
    assign rdy_ok      = rdy_sync_q[1];
    assign rdy_expired = (state_q == StWait) && !rdy_ok && tmr_done;

    isa_cycle_timer #(
        .Width (TimerW)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        unique case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    state_d  = StSetup;
                    tmr_load = 1'b1;
                    tmr_val  = TimerW'(SETUP_CYCLES - 1);
                end
            end
            StSetup: begin
                if (tmr_done) begin
                    state_d  = StStrobe;
                    tmr_load = 1'b1;
                    tmr_val  = TimerW'(STROBE_CYCLES - 1);
                end
            end
            StStrobe: begin
                if (tmr_done) begin
                    tmr_load = 1'b1;
                    if (rdy_ok) begin
                        state_d = StHold;
                        tmr_val = TimerW'(HOLD_CYCLES - 1);
                    end else begin
                        state_d = StWait;
                        tmr_val = TimerW'(RDY_TIMEOUT - 1);
                    end
                end
            end
            StWait: begin
                if (rdy_ok || tmr_done) begin
                    state_d  = StHold;
                    tmr_load = 1'b1;
                    tmr_val  = TimerW'(HOLD_CYCLES - 1);
                end
            end
            StHold: begin
                if (tmr_done) begin
                    state_d = StResp;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cap_d   = cap_q;
        tmo_d   = tmo_q;
        rdata_d = rdata_q;
        if (state_q == StIdle && bus.req_valid) begin
            write_d = bus.req_write;
            addr_d  = bus.req_addr;
            wdata_d = bus.req_wdata;
            tmo_d   = 1'b0;
        end
        if (state_d == StHold && (state_q == StStrobe || state_q == StWait)) begin
            cap_d = (write_q || rdy_expired || !bus.bus_dir) ? FLOAT_DATA : bus.bus_in;
            if (rdy_expired) begin
                tmo_d = 1'b1;
            end
        end
        // Publish only on entry to the response cycle so rsp_rdata holds between responses.
        if (state_q == StHold && state_d == StResp) begin
            rdata_d = cap_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            write_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cap_q      <= FLOAT_DATA;
            rdata_q    <= FLOAT_DATA;
            tmo_q      <= 1'b0;
            rdy_sync_q <= 2'b11;
        end else begin
            write_q    <= write_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cap_q      <= cap_d;
            rdata_q    <= rdata_d;
            tmo_q      <= tmo_d;
            rdy_sync_q <= {rdy_sync_q[0], bus.bus_rdy};
        end
    end

    always_comb begin
        bus.req_ready   = (state_q == StIdle);
        bus.rsp_valid   = 1'b0;
        bus.rsp_timeout = 1'b0;
        bus.rsp_rdata   = rdata_q;
        bus.bus_a       = '0;
        bus.bus_ior_l   = 1'b1;
        bus.bus_iow_l   = 1'b1;
        bus.bus_aen     = 1'b1;
        bus.bus_d_out   = '0;
        bus.bus_d_oe    = 1'b0;
        if (state_q != StIdle && state_q != StResp) begin
            bus.bus_a     = addr_q;
            bus.bus_aen   = 1'b0;
            bus.bus_d_oe  = write_q;
            bus.bus_d_out = wdata_q;
        end
        if (state_q == StStrobe || state_q == StWait) begin
            bus.bus_iow_l = !write_q;
            bus.bus_ior_l = write_q;
        end
        if (state_q == StResp) begin
            bus.rsp_valid   = 1'b1;
            bus.rsp_timeout = tmo_q;
        end
    end

endmodule

// File: tb/tb_cga_io_initiator.sv
// Directed plus randomized bench for cga_io_initiator against a cycle-count reference model.
module tb_cga_io_initiator;
    import cga_io_pkg::*;

    localparam int S  = int'(SETUP_CYCLES_DEF);
    localparam int SC = int'(STROBE_CYCLES_DEF);
    localparam int H  = int'(HOLD_CYCLES_DEF);
    localparam int RT = int'(RDY_TIMEOUT_DEF);

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_assert = 0;
    int   n_fail   = 0;

    cga_io_initiator_if bus_if ();

    cga_io_initiator #(
        .SETUP_CYCLES  (SETUP_CYCLES_DEF),
        .STROBE_CYCLES (STROBE_CYCLES_DEF),
        .HOLD_CYCLES   (HOLD_CYCLES_DEF),
        .RDY_TIMEOUT   (RDY_TIMEOUT_DEF)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Strobes never overlap and never assert while AEN blocks decode.
    always @(negedge clk) begin
        n_assert++;
        assert (!(bus_if.bus_ior_l === 1'b0 && bus_if.bus_iow_l === 1'b0) &&
                !((bus_if.bus_ior_l === 1'b0 || bus_if.bus_iow_l === 1'b0) &&
                  bus_if.bus_aen !== 1'b0)) else begin
            n_fail++;
            $error("FAIL strobe_rules: ior_l %b iow_l %b aen %b, expected no overlap and aen 0",
                   bus_if.bus_ior_l, bus_if.bus_iow_l, bus_if.bus_aen);
        end
    end

    // Strobe length for bus_rdy low during the first 'low' strobe cycles; the initiator
    // reacts to bus_rdy as it stood two cycles earlier.
    function automatic void model_strobe(input int low, output int len, output bit tmo);
        len = 0;
        tmo = 1'b0;
        for (int w = 0; w <= RT; w++) begin
            int i = SC - 1 + w;
            if (len == 0) begin
                if (i - 2 < 0 || i - 2 >= low) begin
                    len = i + 1;
                end else if (w == RT) begin
                    len = i + 1;
                    tmo = 1'b1;
                end
            end
        end
    endfunction

    task automatic run_txn(input string name, input bit wr, input logic [14:0] addr,
                           input logic [7:0] wd, input bit dir, input logic [7:0] din,
                           input int low, input bit hold_valid);
        int         exp_len;
        bit         exp_tmo;
        logic [7:0] exp_rd;
        int         first_lo, last_lo, n_lo, other_lo, bad_bus, busy_ready, rsp_at;
        logic       strobe, other, got_tmo;
        logic [7:0] got_rd;
        model_strobe(low, exp_len, exp_tmo);
        exp_rd = (wr || exp_tmo || !dir) ? 8'hFF : din;

        @(negedge clk);
        check({name, " req_ready_idle"}, 32'(bus_if.req_ready), 32'd1);
        bus_if.req_valid = 1'b1;
        bus_if.req_write = wr;
        bus_if.req_addr  = addr;
        bus_if.req_wdata = wd;
        bus_if.bus_dir   = dir;
        bus_if.bus_in    = din;
        bus_if.bus_rdy   = 1'b1;
        @(posedge clk);

        first_lo = -1; last_lo = -1; n_lo = 0; other_lo = 0;
        bad_bus = 0; busy_ready = 0; rsp_at = -1;
        got_rd = 8'h00; got_tmo = 1'b0;
        for (int j = 0; j < S + SC + RT + H + 8; j++) begin
            @(negedge clk);
            if (!hold_valid) begin
                bus_if.req_valid = 1'b0;
            end
            // Scrambled request fields must not reach the bus mid-transaction.
            bus_if.req_addr  = 15'($urandom);
            bus_if.req_wdata = 8'($urandom);
            bus_if.req_write = 1'($urandom);
            bus_if.bus_rdy   = !((j - S) >= 0 && (j - S) < low);
            strobe = wr ? bus_if.bus_iow_l : bus_if.bus_ior_l;
            other  = wr ? bus_if.bus_ior_l : bus_if.bus_iow_l;
            if (other !== 1'b1) other_lo++;
            if (bus_if.rsp_valid === 1'b1) begin
                rsp_at  = j;
                got_rd  = bus_if.rsp_rdata;
                got_tmo = bus_if.rsp_timeout;
                bus_if.req_valid = 1'b0;
                break;
            end
            if (strobe === 1'b0) begin
                if (first_lo < 0) first_lo = j;
                last_lo = j;
                n_lo++;
            end
            if (bus_if.bus_a !== addr || bus_if.bus_aen !== 1'b0 ||
                bus_if.bus_d_oe !== wr || bus_if.bus_d_out !== wd) bad_bus++;
            if (bus_if.req_ready !== 1'b0) busy_ready++;
        end
        bus_if.bus_rdy = 1'b1;

        check({name, " rsp_latency"}, 32'(rsp_at), 32'(S + exp_len + H));
        check({name, " strobe_start"}, 32'(first_lo), 32'(S));
        check({name, " strobe_cycles"}, 32'(n_lo), 32'(exp_len));
        check({name, " strobe_contiguous"}, 32'(last_lo - first_lo + 1), 32'(exp_len));
        check({name, " other_strobe_low"}, 32'(other_lo), 32'd0);
        check({name, " bus_fields_bad"}, 32'(bad_bus), 32'd0);
        check({name, " ready_while_busy"}, 32'(busy_ready), 32'd0);
        check({name, " rsp_rdata"}, 32'(got_rd), 32'(exp_rd));
        check({name, " rsp_timeout"}, 32'(got_tmo), 32'(exp_tmo));

        @(negedge clk);
        check({name, " rsp_one_cycle"}, 32'(bus_if.rsp_valid), 32'd0);
        check({name, " ready_after"}, 32'(bus_if.req_ready), 32'd1);
        check({name, " rdata_held"}, 32'(bus_if.rsp_rdata), 32'(exp_rd));
    endtask

    initial begin
        int n_rsp, n_busy;
        bus_if.req_valid = 1'b0;
        bus_if.req_write = 1'b0;
        bus_if.req_addr  = '0;
        bus_if.req_wdata = '0;
        bus_if.bus_in    = '0;
        bus_if.bus_dir   = 1'b0;
        bus_if.bus_rdy   = 1'b1;
        #1 reset = 1'b1;
        #1;
        check("reset req_ready", 32'(bus_if.req_ready), 32'd1);
        check("reset bus_a", 32'(bus_if.bus_a), 32'd0);
        check("reset ior_l", 32'(bus_if.bus_ior_l), 32'd1);
        check("reset iow_l", 32'(bus_if.bus_iow_l), 32'd1);
        check("reset aen", 32'(bus_if.bus_aen), 32'd1);
        check("reset d_oe", 32'(bus_if.bus_d_oe), 32'd0);
        check("reset d_out", 32'(bus_if.bus_d_out), 32'd0);
        check("reset rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
        check("reset rsp_rdata", 32'(bus_if.rsp_rdata), 32'hFF);
        check("reset rsp_timeout", 32'(bus_if.rsp_timeout), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        run_txn("wr_3d8", 1'b1, 15'h3D8, 8'h29, 1'b0, 8'h00, 0, 1'b0);
        run_txn("rd_3da", 1'b0, 15'h3DA, 8'h00, 1'b1, 8'hF1, 0, 1'b0);
        run_txn("rd_3df_float", 1'b0, 15'h3DF, 8'h00, 1'b0, 8'h5A, 0, 1'b1);
        run_txn("rd_rdy_low5", 1'b0, 15'h3D5, 8'h00, 1'b1, 8'h3C, 5, 1'b0);
        run_txn("rd_rdy_stuck", 1'b0, 15'h3D4, 8'h00, 1'b1, 8'h77, 1000, 1'b0);
        run_txn("wr_rdy_stuck", 1'b1, 15'h3D9, 8'hA5, 1'b1, 8'h12, 1000, 1'b1);

        // Reset during the second strobe cycle.
        @(negedge clk);
        bus_if.req_valid = 1'b1;
        bus_if.req_write = 1'b0;
        bus_if.req_addr  = 15'h3DA;
        bus_if.bus_dir   = 1'b1;
        bus_if.bus_in    = 8'h66;
        @(posedge clk);
        @(negedge clk);
        bus_if.req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        check("abort strobe_active", 32'(bus_if.bus_ior_l), 32'd0);
        reset = 1'b1;
        #1;
        check("abort ior_l", 32'(bus_if.bus_ior_l), 32'd1);
        check("abort iow_l", 32'(bus_if.bus_iow_l), 32'd1);
        check("abort aen", 32'(bus_if.bus_aen), 32'd1);
        check("abort bus_a", 32'(bus_if.bus_a), 32'd0);
        check("abort rsp_rdata", 32'(bus_if.rsp_rdata), 32'hFF);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        n_rsp = 0;
        n_busy = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus_if.rsp_valid !== 1'b0) n_rsp++;
            if (bus_if.req_ready !== 1'b1) n_busy++;
        end
        check("abort no_rsp_valid", 32'(n_rsp), 32'd0);
        check("abort ready_after", 32'(n_busy), 32'd0);

        for (int k = 0; k < 12; k++) begin
            run_txn("random", 1'($urandom), 15'($urandom), 8'($urandom), 1'($urandom),
                    8'($urandom), int'($urandom_range(0, 9)), 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
